// File: rtl/mul_flag_unit.sv
// Multi-cycle MUL/MLA execute unit: shift-add multiplier with optional accumulate,
// producing the low WIDTH result bits, an NZCV nibble and a one-cycle flag-write strobe.
module mul_flag_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    input  logic             c_in,
    input  logic             v_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       new_states,
    output logic             flag_write
);

    localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST_CNT = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_ACC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   addend_q, addend_d;
    logic               mla_q, mla_d;
    logic               sflag_q, sflag_d;
    logic               c_q, c_d;
    logic               v_q, v_d;

    logic               busy_d;
    logic               done_d;
    logic               flag_write_d;
    logic [WIDTH-1:0]   result_d;
    logic [3:0]         new_states_d;

    logic [WIDTH-1:0]   partial;
    logic               finish;

    // Current partial product: op_a shifted by the bit position being examined.
    assign partial = b_q[count_q] ? (a_q << count_q) : '0;

    // State and operand registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addend_q <= '0;
            mla_q    <= 1'b0;
            sflag_q  <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            addend_q <= addend_d;
            mla_q    <= mla_d;
            sflag_q  <= sflag_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    // Registered outputs, stable for the whole DONE cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            flag_write <= 1'b0;
            result     <= '0;
            new_states <= 4'b0000;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            flag_write <= flag_write_d;
            result     <= result_d;
            new_states <= new_states_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        a_d          = a_q;
        b_d          = b_q;
        addend_d     = addend_q;
        mla_d        = mla_q;
        sflag_d      = sflag_q;
        c_d          = c_q;
        v_d          = v_q;
        finish       = 1'b0;
        done_d       = 1'b0;
        flag_write_d = 1'b0;
        result_d     = result;
        new_states_d = new_states;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    addend_d = op_acc;
                    mla_d    = accumulate;
                    sflag_d  = set_flags;
                    c_d      = c_in;
                    v_d      = v_in;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_MULT;
                end
            end
            S_MULT: begin
                acc_d   = acc_q + partial;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(LAST_CNT)) begin
                    if (mla_q) begin
                        state_d = S_ACC;
                    end else begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end
                end
            end
            S_ACC: begin
                acc_d   = acc_q + addend_q;
                state_d = S_DONE;
                finish  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result and flags are published on the edge that enters DONE.
        if (finish) begin
            done_d       = 1'b1;
            flag_write_d = sflag_q;
            result_d     = acc_d;
            if (sflag_q) begin
                new_states_d = {acc_d[WIDTH-1], (acc_d == '0), c_q, v_q};
            end
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mul_flag_unit.sv
// Self-checking bench for mul_flag_unit: directed spec cases, back-to-back starts,
// mid-operation reset and randomized operations against an arithmetic reference model.
module tb_mul_flag_unit;

    localparam int unsigned WIDTH = 32;

    logic             clock;
    logic             reset;
    logic             start;
    logic             accumulate;
    logic             set_flags;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_acc;
    logic             c_in;
    logic             v_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       new_states;
    logic             flag_write;

    int vectors;
    int errors;
    logic [3:0] exp_ns;

    mul_flag_unit #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .c_in       (c_in),
        .v_in       (v_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .new_states (new_states),
        .flag_write (flag_write)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic [WIDTH-1:0] acc,
                                                      input logic mla);
        logic [2*WIDTH-1:0] full;
        full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        if (mla) full = full + (2*WIDTH)'(acc);
        return full[WIDTH-1:0];
    endfunction

    // Starts one operation and observes cycles 1..ncyc (cycle n follows edge n-1).
    // Extra start pulses with random operands are raised in cycles p1 and p2 (0 = none).
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] acc, input logic mla, input logic s,
                         input logic c, input logic v, input int ncyc,
                         input int p1, input int p2,
                         output int done_cnt, output int done_cyc, output int busy_cnt,
                         output logic [WIDTH-1:0] res, output logic [3:0] ns,
                         output logic fw);
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
        res      = '0;
        ns       = '0;
        fw       = 1'b0;
        op_a = a; op_b = b; op_acc = acc; accumulate = mla;
        set_flags = s; c_in = c; v_in = v; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (cyc == p1 || cyc == p2) begin
                start = 1'b1;
                op_a = $urandom; op_b = $urandom; op_acc = $urandom;
                accumulate = 1'($urandom); set_flags = 1'($urandom);
                c_in = 1'($urandom); v_in = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    res      = result;
                    ns       = new_states;
                    fw       = flag_write;
                end
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0; accumulate = 1'b0; set_flags = 1'b0;
        op_a = '0; op_b = '0; op_acc = '0; c_in = 1'b0; v_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({busy, done, flag_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/fw=%b required 000", {busy, done, flag_write});
        end
        vectors++;
        if (result !== '0 || new_states !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data: result=%h ns=%b required 0 and 0000", result, new_states);
        end
        reset = 1'b0;
        exp_ns = 4'b0000;
        @(posedge clock);
        #1;
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] ta [4];
        logic [WIDTH-1:0] tb [4];
        logic [WIDTH-1:0] tacc [4];
        logic             tmla [4];
        logic             ts [4];
        logic             tc [4];
        logic             tv [4];
        logic [WIDTH-1:0] tres [4];
        int               tlat [4];
        int dc, dcyc, bc;
        logic [WIDTH-1:0] res;
        logic [3:0] ns, want_ns;
        logic fw;
        ta[0] = 32'd3;          tb[0] = 32'd5;          tacc[0] = 32'd99; tmla[0] = 1'b0;
        ts[0] = 1'b1; tc[0] = 1'b1; tv[0] = 1'b0; tres[0] = 32'd15;         tlat[0] = 33;
        ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;          tacc[1] = 32'd0;  tmla[1] = 1'b0;
        ts[1] = 1'b1; tc[1] = 1'b0; tv[1] = 1'b1; tres[1] = 32'hFFFF_FFFF;  tlat[1] = 33;
        ta[2] = 32'h0001_0000;  tb[2] = 32'h0001_0000;  tacc[2] = 32'd0;  tmla[2] = 1'b0;
        ts[2] = 1'b1; tc[2] = 1'b0; tv[2] = 1'b0; tres[2] = 32'd0;          tlat[2] = 33;
        ta[3] = 32'd2;          tb[3] = 32'd3;          tacc[3] = 32'd4;  tmla[3] = 1'b1;
        ts[3] = 1'b0; tc[3] = 1'b1; tv[3] = 1'b1; tres[3] = 32'd10;         tlat[3] = 34;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tacc[i], tmla[i], ts[i], tc[i], tv[i], tlat[i] + 1, 0, 0,
                  dc, dcyc, bc, res, ns, fw);
            if (ts[i]) want_ns = {tres[i][WIDTH-1], (tres[i] == '0), tc[i], tv[i]};
            else       want_ns = exp_ns;
            exp_ns = want_ns;
            vectors++;
            if (dc !== 1 || dcyc !== tlat[i]) begin
                errors++;
                $display("FAIL dir%0d_done: %0d pulses, first in cycle %0d; required 1 in cycle %0d",
                         i, dc, dcyc, tlat[i]);
            end
            vectors++;
            if (res !== tres[i]) begin
                errors++;
                $display("FAIL dir%0d_result: got %h required %h", i, res, tres[i]);
            end
            vectors++;
            if (ns !== want_ns || fw !== ts[i]) begin
                errors++;
                $display("FAIL dir%0d_flags: ns=%b fw=%b required ns=%b fw=%b",
                         i, ns, fw, want_ns, ts[i]);
            end
            vectors++;
            if (bc !== tlat[i]) begin
                errors++;
                $display("FAIL dir%0d_busy: busy for %0d cycles required %0d", i, bc, tlat[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dc, dcyc, bc;
        logic [WIDTH-1:0] res;
        logic [3:0] ns;
        logic fw;
        do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 33, 5, 33,
              dc, dcyc, bc, res, ns, fw);
        exp_ns = 4'b0000;
        vectors++;
        if (dc !== 1 || dcyc !== 33 || res !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: %0d pulses cycle %0d result %h; required 1 at 33 result 0000002a",
                     dc, dcyc, res);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b in cycle after done required 0", busy);
        end
        // Issued in the cycle right after DONE, so it must be accepted.
        do_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 34, 0, 0,
              dc, dcyc, bc, res, ns, fw);
        exp_ns = 4'b0011;
        vectors++;
        if (dc !== 1 || dcyc !== 33 || res !== 32'd81 || ns !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_second: %0d pulses cycle %0d result %h ns %b; required 1 at 33 result 00000051 ns 0011",
                     dc, dcyc, res, ns);
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] a, b, acc, want;
        logic mla, s, c, v;
        logic [3:0] want_ns;
        int lat, dc, dcyc, bc;
        logic [WIDTH-1:0] res;
        logic [3:0] ns;
        logic fw;
        for (int n = 0; n < 24; n++) begin
            a = $urandom; b = $urandom; acc = $urandom;
            case ($urandom_range(0, 4))
                0: b = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                1: a = '0;
                2: begin a = '1; b = '1; end
                default: ;
            endcase
            mla = 1'($urandom); s = 1'($urandom); c = 1'($urandom); v = 1'($urandom);
            want = model_result(a, b, acc, mla);
            lat  = mla ? WIDTH + 2 : WIDTH + 1;
            if (s) exp_ns = {want[WIDTH-1], (want == '0), c, v};
            want_ns = exp_ns;
            do_op(a, b, acc, mla, s, c, v, lat + 1, 0, 0, dc, dcyc, bc, res, ns, fw);
            vectors++;
            if (dc !== 1 || dcyc !== lat) begin
                errors++;
                $display("FAIL rnd%0d_done: %0d pulses cycle %0d required 1 at %0d", n, dc, dcyc, lat);
            end
            vectors++;
            if (res !== want) begin
                errors++;
                $display("FAIL rnd%0d_result: a=%h b=%h acc=%h mla=%b got %h required %h",
                         n, a, b, acc, mla, res, want);
            end
            vectors++;
            if (ns !== want_ns || fw !== s) begin
                errors++;
                $display("FAIL rnd%0d_flags: ns=%b fw=%b required ns=%b fw=%b", n, ns, fw, want_ns, s);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        int dc;
        op_a = 32'd11; op_b = 32'd13; op_acc = 32'd0; accumulate = 1'b1;
        set_flags = 1'b1; c_in = 1'b1; v_in = 1'b1; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_ns = 4'b0000;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || flag_write !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: busy=%b done=%b fw=%b required all 0", busy, done, flag_write);
        end
        vectors++;
        if (result !== '0 || new_states !== exp_ns) begin
            errors++;
            $display("FAIL midrst_data: result=%h ns=%b required 0 and 0000", result, new_states);
        end
        dc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            if (done === 1'b1) dc++;
        end
        vectors++;
        if (dc !== 0) begin
            errors++;
            $display("FAIL midrst_nodone: %0d done pulses after reset required 0", dc);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        exp_ns  = 4'b0000;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
